// File: rtl/ifetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package ifetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } ifetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble beats load, and neither means hold.
module ifid_reg
   import ifetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] pc,
   input  logic [31:0] pcplus,
   input  logic [31:0] instr,
   output logic [31:0] pcD,
   output logic [31:0] pcplusD,
   output logic [31:0] instrD,
   output logic        validD
);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcD     <= '0;
         pcplusD <= '0;
         instrD  <= NOP_INSTR;
         validD  <= 1'b0;
      end else if (bubble) begin
         // pc fields still track IF so a bubble can be traced in a debugger
         pcD     <= pc;
         pcplusD <= pcplus;
         instrD  <= NOP_INSTR;
         validD  <= 1'b0;
      end else if (load) begin
         pcD     <= pc;
         pcplusD <= pcplus;
         instrD  <= instr;
         validD  <= 1'b1;
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: PC, fetch handshake FSM, stall buffer and IF/ID register.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc_addr,
   input  logic        stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pcplus,
   output logic [31:0] pcD,
   output logic [31:0] pcplusD,
   output logic [31:0] instrD,
   output logic        validD,
   output logic        fetch_wait
);

   ifetch_state_t state, state_next;
   logic [31:0]   instr_buf;
   logic          accept;
   logic          capture;
   logic          id_bubble;

   assign pcplus    = pc + PC_STEP;
   assign imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_next;
   end

   // NOTE: every always_comb output gets a default first, so no latch can form.
   always_comb begin
      state_next = state;
      case (state)
         FETCH: if (imem_ready && stall) state_next = HOLD;
         HOLD:  if (!stall)              state_next = FETCH;
         default:                        state_next = FETCH;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      fetch_wait = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      id_bubble  = flush;
      case (state)
         FETCH: begin
            imem_req   = 1'b1;
            fetch_wait = !imem_ready;
            accept     = imem_ready && !stall;
            capture    = imem_ready && stall;
            if (!imem_ready && !stall) id_bubble = 1'b1;
         end
         HOLD:    accept = !stall;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         pc <= RESET_PC;
      else if (accept) pc <= npc_addr;
   end

   // Response captured during a stall is replayed from here instead of re-fetched
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          instr_buf <= '0;
      else if (capture) instr_buf <= imem_rdata;
   end

   ifid_reg u_ifid (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .bubble  (id_bubble),
      .pc      (pc),
      .pcplus  (pcplus),
      .instr   ((state == HOLD) ? instr_buf : imem_rdata),
      .pcD     (pcD),
      .pcplusD (pcplusD),
      .instrD  (instrD),
      .validD  (validD)
   );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized traffic vs a transaction model.
module tb_ifetch;
   import ifetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc_addr;
   logic        stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pcplus;
   logic [31:0] pcD;
   logic [31:0] pcplusD;
   logic [31:0] instrD;
   logic        validD;
   logic        fetch_wait;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: PC, a one-entry "response owed to IF" slot, and ID contents.
   logic [31:0] m_pc;
   logic        m_pend;
   logic [31:0] m_buf;
   logic [31:0] m_pcD, m_pcplusD, m_instrD;
   logic        m_validD;

   ifetch dut (
      .clk        (clk),
      .rst        (rst),
      .npc_addr   (npc_addr),
      .stall      (stall),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .pcplus     (pcplus),
      .pcD        (pcD),
      .pcplusD    (pcplusD),
      .instrD     (instrD),
      .validD     (validD),
      .fetch_wait (fetch_wait)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pc      = 32'h0000_3000;
      m_pend    = 1'b0;
      m_buf     = 32'h0;
      m_pcD     = 32'h0;
      m_pcplusD = 32'h0;
      m_instrD  = 32'h0;
      m_validD  = 1'b0;
   endfunction

   // One clock edge of the fetch stage, expressed as "was an instruction delivered to ID?"
   function automatic void model_step();
      logic        deliver = 1'b0;
      logic        bubble  = flush;
      logic [31:0] word    = 32'h0;
      if (m_pend) begin
         if (!stall) begin deliver = 1'b1; word = m_buf; end
      end else if (imem_ready) begin
         if (!stall) begin deliver = 1'b1; word = imem_rdata; end
      end else if (!stall) begin
         bubble = 1'b1;
      end
      if (bubble || deliver) begin
         m_pcD     = m_pc;
         m_pcplusD = m_pc + 32'd4;
         m_instrD  = bubble ? 32'h0 : word;
         m_validD  = !bubble;
      end
      if (deliver) begin
         m_pc   = npc_addr;
         m_pend = 1'b0;
      end else if (!m_pend && imem_ready && stall) begin
         m_pend = 1'b1;
         m_buf  = imem_rdata;
      end
   endfunction

   task automatic check_front();
      check("imem_req",   {31'b0, imem_req},   {31'b0, !m_pend});
      check("imem_addr",  imem_addr,           m_pc);
      check("fetch_wait", {31'b0, fetch_wait}, {31'b0, !m_pend && !imem_ready});
      check("pcplus",     pcplus,              m_pc + 32'd4);
   endtask

   task automatic check_regs();
      check("pc",      pc,               m_pc);
      check("pcD",     pcD,              m_pcD);
      check("pcplusD", pcplusD,          m_pcplusD);
      check("instrD",  instrD,           m_instrD);
      check("validD",  {31'b0, validD},  {31'b0, m_validD});
   endtask

   // Drive inputs 1 time unit after an edge, check, clock once, check registered state.
   task automatic cycle(input logic rdy, input logic st, input logic fl,
                        input logic [31:0] npc, input logic [31:0] rd);
      imem_ready = rdy;
      stall      = st;
      flush      = fl;
      npc_addr   = npc;
      imem_rdata = rd;
      #1 check_front();
      @(posedge clk);
      model_step();
      #1 check_regs();
   endtask

   initial begin
      rst = 1'b1; npc_addr = '0; stall = 1'b0; flush = 1'b0;
      imem_ready = 1'b0; imem_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_pc",     pc,                  32'h0000_3000);
      check("reset_req",    {31'b0, imem_req},   32'd1);
      check("reset_validD", {31'b0, validD},     32'd0);
      check("reset_pcD",    pcD,                 32'd0);
      check_regs();

      // Zero-wait stream
      cycle(1'b1, 1'b0, 1'b0, pcplus, 32'hA000_0000);
      check("zw_pc1",     pc,      32'h0000_3004);
      check("zw_pcD1",    pcD,     32'h0000_3000);
      check("zw_instrD1", instrD,  32'hA000_0000);
      check("zw_pcplusD", pcplusD, 32'h0000_3004);

      // Memory wait at 0x3004
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'hDEAD_0000, 32'hBAD0_0000);
         check("wait_addr",   imem_addr,          32'h0000_3004);
         check("wait_validD", {31'b0, validD},    32'd0);
      end
      cycle(1'b1, 1'b0, 1'b0, pcplus, 32'hA000_0004);
      check("wait_done_pc", pc,     32'h0000_3008);
      check("wait_instrD",  instrD, 32'hA000_0004);

      // Response during stall: buffered, no re-request
      cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_0000, 32'h2402_0005);
      check("hold_req", {31'b0, imem_req}, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'hDEAD_0000, 32'hBAD0_0001);
      check("hold_pc", pc, 32'h0000_3008);
      cycle(1'b0, 1'b0, 1'b0, pcplus, 32'hBAD0_0002);
      check("hold_instrD", instrD, 32'h2402_0005);
      check("hold_pc_adv", pc,     32'h0000_300C);

      // Branch redirect with flush
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_3040, 32'hA000_000C);
      check("br_pc",     pc,               32'h0000_3040);
      check("br_validD", {31'b0, validD},  32'd0);
      cycle(1'b1, 1'b0, 1'b0, pcplus, 32'hA000_0040);
      check("br_pcD",    pcD,              32'h0000_3040);

      // Stall + flush in FETCH
      cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_0000, 32'h0);
      check("sf_pc",     pc,               32'h0000_3044);
      check("sf_validD", {31'b0, validD},  32'd0);

      // Reset while in HOLD
      cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_0000, 32'h1234_5678);
      #2 rst = 1'b1;
      model_reset();
      #1 check("rst_hold_pc", pc, 32'h0000_3000);
      @(negedge clk);
      rst = 1'b0;
      check("rst_hold_req",    {31'b0, imem_req}, 32'd1);
      check("rst_hold_validD", {31'b0, validD},   32'd0);
      cycle(1'b1, 1'b0, 1'b0, pcplus, 32'h0BAD_BEEF);
      check("rst_no_buf", instrD, 32'h0BAD_BEEF);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] npc;
         npc = ($urandom_range(3) == 0) ? $urandom : m_pc + 32'd4;
         cycle($urandom_range(9) < 7, $urandom_range(3) == 0, $urandom_range(9) == 0,
               npc, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
